// File: rtl/membuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : membuf_pkg
// Brief    : Shared widths, entry layout and byte-lane helpers for membuf.
// Revision : 1.0 - initial release
// ============================================================================
package membuf_pkg;

   localparam int XLEN      = 32;
   localparam int MEMB_PARA = 9;

   // funct3[1:0] access size codes
   localparam logic [1:0] c_SZ_BYTE = 2'b00;
   localparam logic [1:0] c_SZ_HALF = 2'b01;

   localparam logic [2:0] c_F3_LB  = 3'b000;
   localparam logic [2:0] c_F3_LH  = 3'b001;
   localparam logic [2:0] c_F3_LBU = 3'b100;
   localparam logic [2:0] c_F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] funct3;
      logic       is_store;
   } para_t;

   typedef struct packed {
      para_t           para;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } entry_t;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         c_SZ_BYTE: be = 4'b0001 << a;
         c_SZ_HALF: be = 4'b0011 << {a[1], 1'b0};
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] wd);
      logic [XLEN-1:0] res;
      case (size)
         c_SZ_BYTE: res = {4{wd[7:0]}};
         c_SZ_HALF: res = {2{wd[15:0]}};
         default:   res = wd;
      endcase
      return res;
   endfunction

   // Half accesses ignore addr[0] so the lane always matches the byte enables.
   function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [XLEN-1:0] rdata);
      logic [4:0]      shamt;
      logic [XLEN-1:0] lane;
      logic [XLEN-1:0] res;
      case (f3[1:0])
         c_SZ_BYTE: shamt = {a, 3'b000};
         c_SZ_HALF: shamt = {a[1], 4'b0000};
         default:   shamt = 5'd0;
      endcase
      lane = rdata >> shamt;
      case (f3)
         c_F3_LB:  res = {{(XLEN-8){lane[7]}}, lane[7:0]};
         c_F3_LH:  res = {{(XLEN-16){lane[15]}}, lane[15:0]};
         c_F3_LBU: res = {{(XLEN-8){1'b0}}, lane[7:0]};
         c_F3_LHU: res = {{(XLEN-16){1'b0}}, lane[15:0]};
         default:  res = lane;
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/membuf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : membuf_fifo
// Brief    : DEPTH-entry register FIFO with wrap-bit pointers and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module membuf_fifo #(
   parameter int WIDTH = 73,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      count,
   output logic             empty
);

   localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // Occupancy falls out of the wrap-bit pointer difference.
   assign count  = r_wr_ptr - r_rd_ptr;
   assign empty  = (r_wr_ptr == r_rd_ptr);
   assign w_push = push & (count != c_FULL);
   assign w_pop  = pop & ~empty;
   assign rdata  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/membuf.sv
`default_nettype none
// ============================================================================
// Module   : membuf
// Brief    : In-order load/store buffer issuing to a single-outstanding bus.
// Revision : 1.0 - initial release
// ============================================================================
module membuf
   import membuf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_vld,
   input  logic [MEMB_PARA-1:0] in_para,
   input  logic [XLEN-1:0]      in_addr,
   input  logic [XLEN-1:0]      in_wdata,
   output logic                 membuf_full,
   output logic                 membuf_empty,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [XLEN-1:0]      dmem_addr,
   output logic [3:0]           dmem_be,
   output logic [XLEN-1:0]      dmem_wdata,
   input  logic                 dmem_gnt,
   input  logic                 dmem_rvalid,
   input  logic [XLEN-1:0]      dmem_rdata,
   output logic                 ld_vld,
   output logic [4:0]           ld_sel,
   output logic [XLEN-1:0]      ld_data
);

   state_t          r_state;
   state_t          w_next_state;
   entry_t          w_in_entry;
   entry_t          w_head;
   logic [AW:0]     w_count;
   logic            w_fifo_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_ld_done;
   logic            r_ld_vld;
   logic [4:0]      r_ld_sel;
   logic [XLEN-1:0] r_ld_data;

   assign w_in_entry  = {in_para, in_addr, in_wdata};
   // Full comes from registered occupancy only: a same-cycle pop never frees a slot.
   assign membuf_full = (w_count == (AW+1)'(DEPTH));
   assign w_push      = in_vld & ~membuf_full;
   assign w_ld_done   = (r_state == S_WAIT) & dmem_rvalid;
   assign w_pop       = ((r_state == S_REQ) & dmem_gnt & w_head.para.is_store) | w_ld_done;

   membuf_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (w_in_entry),
      .rdata (w_head),
      .count (w_count),
      .empty (w_fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      dmem_addr    = '0;
      dmem_be      = 4'b0000;
      dmem_wdata   = '0;
      case (r_state)
         S_IDLE: begin
            if (!w_fifo_empty) w_next_state = S_REQ;
         end
         S_REQ: begin
            dmem_req   = 1'b1;
            dmem_we    = w_head.para.is_store;
            dmem_addr  = {w_head.addr[XLEN-1:2], 2'b00};
            dmem_be    = byte_en(w_head.para.funct3[1:0], w_head.addr[1:0]);
            dmem_wdata = lane_wdata(w_head.para.funct3[1:0], w_head.wdata);
            if (dmem_gnt) w_next_state = w_head.para.is_store ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (dmem_rvalid) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Head entry still describes the load while in WAIT; it pops on this same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ld_vld  <= 1'b0;
         r_ld_sel  <= '0;
         r_ld_data <= '0;
      end else begin
         r_ld_vld <= w_ld_done;
         if (w_ld_done) begin
            r_ld_sel  <= w_head.para.rd;
            r_ld_data <= load_ext(w_head.para.funct3, w_head.addr[1:0], dmem_rdata);
         end
      end
   end

   assign ld_vld       = r_ld_vld;
   assign ld_sel       = r_ld_sel;
   assign ld_data      = r_ld_data;
   assign membuf_empty = w_fifo_empty & (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_membuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_membuf
// Brief    : Scoreboard bench for membuf with a transaction-level bus model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_membuf;

   logic        clk;
   logic        rst;
   logic        in_vld;
   logic [8:0]  in_para;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        membuf_full;
   logic        membuf_empty;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        ld_vld;
   logic [4:0]  ld_sel;
   logic [31:0] ld_data;

   membuf #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_para(in_para), .in_addr(in_addr),
      .in_wdata(in_wdata), .membuf_full(membuf_full), .membuf_empty(membuf_empty),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .ld_vld(ld_vld), .ld_sel(ld_sel), .ld_data(ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
   typedef struct { logic [4:0] rd; logic [2:0] f3; logic [31:0] addr; } lop_t;
   typedef struct { logic [4:0] sel; logic [31:0] data; } ldres_t;

   bus_t   bus_q[$];
   lop_t   lop_q[$];
   ldres_t ld_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // bus-responder knobs
   int          gnt_pct  = 100;
   int          rv_max   = 0;
   bit          hold_rv  = 0;
   bit          stray_en = 0;
   bit          force_en = 0;
   logic [31:0] force_rdata = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
      int a  = int'(addr & 32'd3);
      int sz = int'(f3 & 3'd3);
      if (sz == 0) return 4'(1 << a);
      if (sz == 1) return 4'(3 << ((a / 2) * 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int sz = int'(f3 & 3'd3);
      if (sz == 0) return (wd & 32'hFF) * 32'h0101_0101;
      if (sz == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      int    a   = int'(addr & 32'd3);
      int    sz  = int'(f3 & 3'd3);
      bit    sgn = (f3 < 3'd4);
      longint v;
      if (sz == 0) begin
         v = longint'((rdata >> (8 * a)) & 32'hFF);
         if (sgn && v > 127) v = v - 256;
      end else if (sz == 1) begin
         v = longint'((rdata >> (16 * (a / 2))) & 32'hFFFF);
         if (sgn && v > 32767) v = v - 65536;
      end else begin
         v = longint'(rdata);
      end
      return 32'(v);
   endfunction

   task automatic model_push(input logic [4:0] rd, input logic [2:0] f3, input logic st,
                             input logic [31:0] addr, input logic [31:0] wd);
      bus_t b;
      lop_t l;
      b.we    = st;
      b.addr  = addr - (addr % 4);
      b.be    = m_be(f3, addr);
      b.wdata = m_wdata(f3, wd);
      bus_q.push_back(b);
      if (!st) begin
         l.rd = rd; l.f3 = f3; l.addr = addr;
         lop_q.push_back(l);
      end
   endtask

   // ---------------- bus responder ----------------
   initial begin : responder
      bit pending;
      bit stale;
      int rv_wait;
      lop_t   l;
      ldres_t r;
      pending = 0; stale = 0; rv_wait = 0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (pending) stale = 1;
         end else begin
            if (dmem_rvalid && pending) begin
               if (!stale) begin
                  if (lop_q.size() == 0) check("ld_model_underflow", 32'(lop_q.size()), 1);
                  else begin
                     l = lop_q.pop_front();
                     r.sel  = l.rd;
                     r.data = m_load(l.f3, l.addr, dmem_rdata);
                     ld_q.push_back(r);
                  end
               end
               pending = 0;
               stale   = 0;
            end
            if (dmem_req && dmem_gnt && !dmem_we) begin
               pending = 1;
               stale   = 0;
               rv_wait = $urandom_range(0, rv_max);
            end
         end
         @(posedge clk);
         #2;
         dmem_gnt = ($urandom_range(0, 99) < gnt_pct);
         if (pending && !hold_rv && rv_wait == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = force_en ? force_rdata : $urandom;
         end else begin
            if (pending && rv_wait > 0) rv_wait--;
            dmem_rvalid = !pending && stray_en && ($urandom_range(0, 3) == 0);
            dmem_rdata  = $urandom;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : monitor
      bus_t   e;
      ldres_t r;
      if (!rst) begin
         if (dmem_req && dmem_gnt) begin
            if (bus_q.size() == 0) check("bus_unexpected_issue", 32'(dmem_req), 0);
            else begin
               e = bus_q.pop_front();
               check("bus_we", 32'(dmem_we), 32'(e.we));
               check("bus_addr", dmem_addr, e.addr);
               check("bus_be", 32'(dmem_be), 32'(e.be));
               if (e.we) check("bus_wdata", dmem_wdata, e.wdata);
            end
         end
         if (ld_vld) begin
            if (ld_q.size() == 0) check("ld_unexpected_pulse", 32'(ld_vld), 0);
            else begin
               r = ld_q.pop_front();
               check("ld_sel", 32'(ld_sel), 32'(r.sel));
               check("ld_data", ld_data, r.data);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input logic [4:0] rd, input logic [2:0] f3, input logic st,
                          input logic [31:0] addr, input logic [31:0] wd);
      int g = 0;
      while (membuf_full && g < 300) begin tick(); g++; end
      if (membuf_full) begin
         check("push_wait_full", 32'(membuf_full), 0);
         return;
      end
      in_vld = 1'b1; in_para = {rd, f3, st}; in_addr = addr; in_wdata = wd;
      model_push(rd, f3, st, addr, wd);
      tick();
      in_vld = 1'b0;
   endtask

   task automatic wait_req();
      int g = 0;
      while (!dmem_req && g < 50) begin tick(); g++; end
      if (!dmem_req) check("req_timeout", 32'(dmem_req), 1);
   endtask

   task automatic wait_ld(input string name, input logic [4:0] sel, input logic [31:0] data);
      int g = 0;
      while (!ld_vld && g < 50) begin tick(); g++; end
      if (!ld_vld) check({name, "_timeout"}, 32'(ld_vld), 1);
      else begin
         check({name, "_sel"}, 32'(ld_sel), 32'(sel));
         check({name, "_data"}, ld_data, data);
         tick();
         check({name, "_pulse_width"}, 32'(ld_vld), 0);
      end
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while (!(membuf_empty && ld_q.size() == 0 && bus_q.size() == 0) && g < 3000) begin
         tick(); g++;
      end
      check({name, "_drained"}, {29'b0, membuf_empty, 1'(ld_q.size() == 0), 1'(bus_q.size() == 0)},
            32'h7);
   endtask

   initial begin : stim
      int blocked;
      int seen;
      bit accepted;
      logic [2:0] ld_f3 [5];
      ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
      ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

      rst = 1'b1; in_vld = 1'b0; in_para = '0; in_addr = '0; in_wdata = '0;
      repeat (2) tick();
      check("rst_empty", 32'(membuf_empty), 1);
      check("rst_full", 32'(membuf_full), 0);
      check("rst_req", 32'(dmem_req), 0);
      check("rst_be", 32'(dmem_be), 0);
      check("rst_ld_vld", 32'(ld_vld), 0);
      check("rst_ld_data", ld_data, 0);
      rst = 1'b0;
      tick();

      // SW x5 @0x104, grant in the request cycle
      gnt_pct = 100;
      push_op(5'd5, 3'b010, 1'b1, 32'h104, 32'hAABB_CCDD);
      check("sw_not_empty", 32'(membuf_empty), 0);
      tick();
      check("sw_req", 32'(dmem_req), 1);
      check("sw_we", 32'(dmem_we), 1);
      check("sw_addr", dmem_addr, 32'h104);
      check("sw_be", 32'(dmem_be), 32'hF);
      tick();
      check("sw_empty_after", 32'(membuf_empty), 1);

      // LB / LBU rd=3 @0x1003
      force_en = 1; force_rdata = 32'h80FF_FFFF; rv_max = 0;
      push_op(5'd3, 3'b000, 1'b0, 32'h1003, 32'h0);
      wait_req();
      check("lb_be", 32'(dmem_be), 32'h8);
      check("lb_addr", dmem_addr, 32'h1000);
      wait_ld("lb", 5'd3, 32'hFFFF_FF80);
      push_op(5'd3, 3'b100, 1'b0, 32'h1003, 32'h0);
      wait_ld("lbu", 5'd3, 32'h0000_0080);

      // SH then LHU @0x2002
      push_op(5'd1, 3'b001, 1'b1, 32'h2002, 32'h0000_1234);
      wait_req();
      check("sh_be", 32'(dmem_be), 32'hC);
      check("sh_wdata", dmem_wdata, 32'h1234_1234);
      wait_idle("sh");
      force_rdata = 32'h1234_0000;
      push_op(5'd7, 3'b101, 1'b0, 32'h2002, 32'h0);
      wait_ld("lhu", 5'd7, 32'h0000_1234);
      force_en = 0;
      wait_idle("lhu");

      // Fill with grant held low; fifth push blocked until the first grant
      gnt_pct = 0; rv_max = 1;
      for (int i = 0; i < 4; i++)
         push_op(5'(i + 10), (i == 2) ? 3'b010 : 3'b000, (i != 2), 32'h300 + 32'(4 * i),
                 32'h11 * 32'(i + 1));
      check("fill_full", 32'(membuf_full), 1);
      in_vld = 1'b1; in_para = {5'd20, 3'b010, 1'b1}; in_addr = 32'h400; in_wdata = 32'hCAFE_F00D;
      blocked = 0; accepted = 0;
      for (int g = 0; g < 60 && !accepted; g++) begin
         if (!membuf_full) begin
            model_push(5'd20, 3'b010, 1'b1, 32'h400, 32'hCAFE_F00D);
            accepted = 1;
         end else begin
            blocked++;
            if (blocked == 3) gnt_pct = 100;
         end
         tick();
      end
      in_vld = 1'b0;
      check("fifth_accepted", 32'(accepted), 1);
      check("fifth_blocked", 32'(blocked >= 3), 1);
      wait_idle("fill");

      // Push during a pop at count=2 keeps occupancy at 2
      gnt_pct = 0;
      push_op(5'd1, 3'b010, 1'b1, 32'h500, 32'h1);
      push_op(5'd2, 3'b010, 1'b1, 32'h504, 32'h2);
      in_vld = 1'b1; in_para = {5'd3, 3'b010, 1'b1}; in_addr = 32'h508; in_wdata = 32'h3;
      model_push(5'd3, 3'b010, 1'b1, 32'h508, 32'h3);
      gnt_pct = 100;
      tick();
      in_vld = 1'b0;
      gnt_pct = 0;
      push_op(5'd4, 3'b010, 1'b1, 32'h50C, 32'h4);
      check("cnt3_not_full", 32'(membuf_full), 0);
      push_op(5'd5, 3'b010, 1'b1, 32'h510, 32'h5);
      check("cnt4_full", 32'(membuf_full), 1);
      gnt_pct = 100;
      wait_idle("pushpop");

      // Stray rvalid while idle
      stray_en = 1; seen = 0;
      for (int i = 0; i < 16; i++) begin tick(); seen += int'(ld_vld); end
      stray_en = 0;
      check("stray_no_ld", 32'(seen), 0);

      // Reset while waiting for load data, then a late rvalid
      hold_rv = 1;
      push_op(5'd9, 3'b010, 1'b0, 32'h600, 32'h0);
      wait_req();
      tick();
      check("wait_req_low", 32'(dmem_req), 0);
      rst = 1'b1;
      bus_q.delete(); lop_q.delete(); ld_q.delete();
      tick();
      tick();
      rst = 1'b0;
      hold_rv = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin tick(); seen += int'(ld_vld); end
      check("rst_wait_no_ld", 32'(seen), 0);
      check("rst_wait_empty", 32'(membuf_empty), 1);
      check("rst_wait_req", 32'(dmem_req), 0);

      // Randomized traffic
      gnt_pct = 50; rv_max = 3; stray_en = 1;
      for (int i = 0; i < 80; i++) begin
         logic st;
         logic [2:0] f3;
         st = 1'($urandom_range(0, 1));
         f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
         push_op(5'($urandom), f3, st, $urandom, $urandom);
         repeat ($urandom_range(0, 2)) tick();
      end
      gnt_pct = 100;
      wait_idle("random");
      stray_en = 0;
      repeat (4) tick();
      check("final_lop_q", 32'(lop_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time 0x%08h reached, expected finish earlier", 32'(300000));
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
